// File: rtl/ad9643_pkg.sv
// Shared constants for the AD9643 register file: addresses, reset values,
// chip identity and writable-bit masks.
package ad9643_pkg;

  localparam logic [12:0] ADDR_SPI_CFG    = 13'h000;
  localparam logic [12:0] ADDR_CHIP_ID    = 13'h001;
  localparam logic [12:0] ADDR_CHIP_GRADE = 13'h002;
  localparam logic [12:0] ADDR_CH_INDEX   = 13'h005;
  localparam logic [12:0] ADDR_PWR_MODE   = 13'h008;
  localparam logic [12:0] ADDR_CLK_DIV    = 13'h00B;
  localparam logic [12:0] ADDR_TEST_MODE  = 13'h00D;
  localparam logic [12:0] ADDR_OUT_MODE   = 13'h014;
  localparam logic [12:0] ADDR_TRANSFER   = 13'h0FF;

  localparam logic [7:0] RST_SPI_CFG   = 8'h18;
  localparam logic [7:0] RST_CH_INDEX  = 8'h03;
  localparam logic [7:0] RST_PWR_MODE  = 8'h00;
  localparam logic [7:0] RST_CLK_DIV   = 8'h00;
  localparam logic [7:0] RST_TEST_MODE = 8'h00;
  localparam logic [7:0] RST_OUT_MODE  = 8'h00;

  localparam logic [7:0] CHIP_ID    = 8'h82;
  localparam logic [7:0] CHIP_GRADE = 8'h40;

  localparam logic [7:0] MASK_CH_INDEX  = 8'h03;
  localparam logic [7:0] MASK_PWR_MODE  = 8'h03;
  localparam logic [7:0] MASK_CLK_DIV   = 8'h3F;
  localparam logic [7:0] MASK_TEST_MODE = 8'hFF;
  localparam logic [7:0] MASK_OUT_MODE  = 8'hFF;

  // SPI config bits 5 and 2 both request a soft reset
  localparam logic [7:0] SOFT_RST_BITS = 8'h24;

  function automatic logic is_soft_reset(input logic [7:0] data);
    return |(data & SOFT_RST_BITS);
  endfunction

endpackage

// File: rtl/ad9643_shadow_reg.sv
// 8-bit staged/active register pair; staged loads on we, active loads staged on xfer.
// Without AD9643_TRANSFER_EN the active copy is simply the staged copy.
module ad9643_shadow_reg
  import ad9643_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00,
  parameter logic [7:0] MASK    = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wr_data,
  input  logic       xfer,
  output logic [7:0] staged,
  output logic [7:0] active
);

  always_ff @(posedge clk) begin
    if (reset)   staged <= RST_VAL;
    else if (we) staged <= wr_data & MASK;
  end

`ifdef AD9643_TRANSFER_EN
  always_ff @(posedge clk) begin
    if (reset)     active <= RST_VAL;
    else if (xfer) active <= staged;
  end
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
  assign active      = staged;
`endif

endmodule

// File: rtl/ad9643_reg_file.sv
// AD9643 control/status registers: edge-triggered commits, 1-cycle registered read.
// AD9643_TRANSFER_EN enables the staged/active shadow copy with the 0xFF transfer register.
module ad9643_reg_file
  import ad9643_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [12:0] Addr,
  input  logic [7:0]  wrData,
  output logic [7:0]  rdData,
  output logic [7:0]  clock_divide
);

  logic       write_q;
  logic       soft_pend;
  logic       commit;
  logic       rst_all;
  logic       xfer_go;
  logic       xfer_bit;
  logic [7:0] ch_index;
  logic [7:0] pwr_mode;
  logic [7:0] clk_div_stg, clk_div_act;
  logic [7:0] test_stg, unused_test_act;
  logic [7:0] out_stg, unused_out_act;
  logic [7:0] rd_next;

  // An edge landing while a soft reset is being applied is dropped
  assign commit  = write & ~write_q & ~soft_pend;
  assign rst_all = reset | soft_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q   <= 1'b0;
      soft_pend <= 1'b0;
    end else begin
      write_q   <= write;
      soft_pend <= commit && (Addr == ADDR_SPI_CFG) && is_soft_reset(wrData);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      ch_index <= RST_CH_INDEX;
      pwr_mode <= RST_PWR_MODE;
    end else if (commit) begin
      if (Addr == ADDR_CH_INDEX) ch_index <= wrData & MASK_CH_INDEX;
      if (Addr == ADDR_PWR_MODE) pwr_mode <= wrData & MASK_PWR_MODE;
    end
  end

`ifdef AD9643_TRANSFER_EN
  assign xfer_go = commit && (Addr == ADDR_TRANSFER) && wrData[0];

  // Self-clearing: high for the single cycle after the transfer commit
  always_ff @(posedge clk) begin
    if (rst_all) xfer_bit <= 1'b0;
    else         xfer_bit <= xfer_go;
  end
`else
  assign xfer_go  = 1'b0;
  assign xfer_bit = 1'b0;
`endif

  ad9643_shadow_reg #(.RST_VAL(RST_CLK_DIV), .MASK(MASK_CLK_DIV)) u_clk_div (
    .clk(clk), .reset(rst_all), .we(commit && (Addr == ADDR_CLK_DIV)),
    .wr_data(wrData), .xfer(xfer_go), .staged(clk_div_stg), .active(clk_div_act)
  );

  ad9643_shadow_reg #(.RST_VAL(RST_TEST_MODE), .MASK(MASK_TEST_MODE)) u_test_mode (
    .clk(clk), .reset(rst_all), .we(commit && (Addr == ADDR_TEST_MODE)),
    .wr_data(wrData), .xfer(xfer_go), .staged(test_stg), .active(unused_test_act)
  );

  ad9643_shadow_reg #(.RST_VAL(RST_OUT_MODE), .MASK(MASK_OUT_MODE)) u_out_mode (
    .clk(clk), .reset(rst_all), .we(commit && (Addr == ADDR_OUT_MODE)),
    .wr_data(wrData), .xfer(xfer_go), .staged(out_stg), .active(unused_out_act)
  );

  always_comb begin
    rd_next = 8'h00;
    case (Addr)
      ADDR_SPI_CFG:    rd_next = RST_SPI_CFG;
      ADDR_CHIP_ID:    rd_next = CHIP_ID;
      ADDR_CHIP_GRADE: rd_next = CHIP_GRADE;
      ADDR_CH_INDEX:   rd_next = ch_index;
      ADDR_PWR_MODE:   rd_next = pwr_mode;
      ADDR_CLK_DIV:    rd_next = clk_div_stg;
      ADDR_TEST_MODE:  rd_next = test_stg;
      ADDR_OUT_MODE:   rd_next = out_stg;
      ADDR_TRANSFER:   rd_next = {7'b0, xfer_bit};
      default:         rd_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rdData <= 8'h00;
    else       rdData <= rd_next;
  end

  assign clock_divide = clk_div_act & MASK_CLK_DIV;

endmodule

// File: tb/tb_ad9643_reg_file.sv
// Directed bench for ad9643_reg_file; covers both AD9643_TRANSFER_EN builds.
module tb_ad9643_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [12:0] Addr;
  logic [7:0]  wrData;
  logic [7:0]  rdData;
  logic [7:0]  clock_divide;

  int errors = 0;
  int checks = 0;

  ad9643_reg_file dut (
    .clk(clk), .reset(reset), .write(write), .Addr(Addr),
    .wrData(wrData), .rdData(rdData), .clock_divide(clock_divide)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean write edge: commit on the first edge, write low on the second
  task automatic wr(input logic [12:0] a, input logic [7:0] d);
    Addr = a; wrData = d; write = 1'b1;
    tick();
    write = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [12:0] a);
    Addr = a;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b1; Addr = 13'h005; wrData = 8'h01;
    tick(); tick();
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h want 00", rdData); end
    checks++; if (clock_divide !== 8'h00) begin errors++; $display("FAIL reset_div: got %h want 00", clock_divide); end
    write = 1'b0; Addr = 13'h000;
    tick();
    reset = 1'b0;
    tick();
    rd(13'h000);
    checks++; if (rdData !== 8'h18) begin errors++; $display("FAIL rd_spi_cfg: got %h want 18", rdData); end
    rd(13'h001);
    checks++; if (rdData !== 8'h82) begin errors++; $display("FAIL rd_chip_id: got %h want 82", rdData); end
    rd(13'h005);
    checks++; if (rdData !== 8'h03) begin errors++; $display("FAIL rd_ch_index: got %h want 03", rdData); end
    checks++; if (clock_divide !== 8'h00) begin errors++; $display("FAIL post_reset_div: got %h want 00", clock_divide); end
  endtask

  task automatic test_reset_release_edge();
    reset = 1'b1; write = 1'b1; Addr = 13'h008; wrData = 8'h02;
    tick(); tick();
    reset = 1'b0;
    tick();
    wrData = 8'h03;
    tick(); tick(); tick();
    write = 1'b0;
    tick();
    rd(13'h008);
    checks++; if (rdData !== 8'h02) begin errors++; $display("FAIL release_edge: got %h want 02", rdData); end
  endtask

  task automatic test_write_readback();
    wr(13'h008, 8'hFF); rd(13'h008);
    checks++; if (rdData !== 8'h03) begin errors++; $display("FAIL pwr_mask: got %h want 03", rdData); end
    wr(13'h005, 8'hFE); rd(13'h005);
    checks++; if (rdData !== 8'h02) begin errors++; $display("FAIL ch_mask: got %h want 02", rdData); end
    wr(13'h00D, 8'hA5); rd(13'h00D);
    checks++; if (rdData !== 8'hA5) begin errors++; $display("FAIL test_mode: got %h want a5", rdData); end
    wr(13'h014, 8'h3C); rd(13'h014);
    checks++; if (rdData !== 8'h3C) begin errors++; $display("FAIL out_mode: got %h want 3c", rdData); end
    wr(13'h002, 8'h11); rd(13'h002);
    checks++; if (rdData !== 8'h40) begin errors++; $display("FAIL chip_grade: got %h want 40", rdData); end
  endtask

  task automatic test_latency();
    Addr = 13'h00D; wrData = 8'h5A; write = 1'b1;
    tick();
    checks++; if (rdData !== 8'hA5) begin errors++; $display("FAIL lat_edge: got %h want a5", rdData); end
    write = 1'b0;
    tick();
    checks++; if (rdData !== 8'h5A) begin errors++; $display("FAIL lat_2cyc: got %h want 5a", rdData); end
  endtask

  task automatic test_ro_unmapped();
    wr(13'h001, 8'h55);
    wr(13'h1000, 8'hAA);
    wr(13'h10B, 8'h3F);
    rd(13'h001);
    checks++; if (rdData !== 8'h82) begin errors++; $display("FAIL ro_id: got %h want 82", rdData); end
    rd(13'h1000);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL rd_1000: got %h want 00", rdData); end
    rd(13'h10B);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL rd_10b: got %h want 00", rdData); end
    rd(13'h00B);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL alias_0b: got %h want 00", rdData); end
    rd(13'h003);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL rd_003: got %h want 00", rdData); end
    checks++; if (clock_divide !== 8'h00) begin errors++; $display("FAIL alias_div: got %h want 00", clock_divide); end
  endtask

  task automatic test_clk_div();
`ifdef AD9643_TRANSFER_EN
    Addr = 13'h00B; wrData = 8'h2B; write = 1'b1;
    tick();
    write = 1'b0;
    checks++; if (clock_divide !== 8'h00) begin errors++; $display("FAIL div_staged_only: got %h want 00", clock_divide); end
    tick();
    checks++; if (rdData !== 8'h2B) begin errors++; $display("FAIL rd_staged: got %h want 2b", rdData); end
    checks++; if (clock_divide !== 8'h00) begin errors++; $display("FAIL div_no_xfer: got %h want 00", clock_divide); end
    Addr = 13'h0FF; wrData = 8'h01; write = 1'b1;
    tick();
    checks++; if (clock_divide !== 8'h2B) begin errors++; $display("FAIL div_xfer: got %h want 2b", clock_divide); end
    write = 1'b0;
    tick();
    checks++; if (rdData !== 8'h01) begin errors++; $display("FAIL xfer_bit_set: got %h want 01", rdData); end
    tick();
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL xfer_bit_clr: got %h want 00", rdData); end
`else
    Addr = 13'h00B; wrData = 8'h03; write = 1'b1;
    tick();
    checks++; if (clock_divide !== 8'h03) begin errors++; $display("FAIL div_direct: got %h want 03", clock_divide); end
    write = 1'b0;
    tick();
    checks++; if (rdData !== 8'h03) begin errors++; $display("FAIL rd_div: got %h want 03", rdData); end
    wr(13'h0FF, 8'h01); rd(13'h0FF);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL rd_xfer: got %h want 00", rdData); end
    checks++; if (clock_divide !== 8'h03) begin errors++; $display("FAIL div_after_ff: got %h want 03", clock_divide); end
`endif
  endtask

  task automatic test_hold_write();
    Addr = 13'h00B; wrData = 8'hC5; write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin Addr = 13'h00D; wrData = 8'h77; end
      tick();
    end
    write = 1'b0;
    tick();
    rd(13'h00D);
    checks++; if (rdData !== 8'h5A) begin errors++; $display("FAIL hold_no_recommit: got %h want 5a", rdData); end
    rd(13'h00B);
    checks++; if (rdData !== 8'h05) begin errors++; $display("FAIL hold_div: got %h want 05", rdData); end
`ifdef AD9643_TRANSFER_EN
    checks++; if (clock_divide !== 8'h2B) begin errors++; $display("FAIL hold_pre_xfer: got %h want 2b", clock_divide); end
    Addr = 13'h0FF; wrData = 8'h01; write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) begin
        checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL hold_xfer_bit: got %h want 00", rdData); end
      end
    end
    write = 1'b0;
    tick();
`endif
    checks++; if (clock_divide !== 8'h05) begin errors++; $display("FAIL hold_div_out: got %h want 05", clock_divide); end
  endtask

  task automatic test_soft_reset();
    wr(13'h00B, 8'h07);
`ifdef AD9643_TRANSFER_EN
    wr(13'h0FF, 8'h01);
`endif
    checks++; if (clock_divide !== 8'h07) begin errors++; $display("FAIL pre_soft_div: got %h want 07", clock_divide); end
    wr(13'h008, 8'h01);
    wr(13'h000, 8'h24);
    checks++; if (clock_divide !== 8'h00) begin errors++; $display("FAIL soft_div: got %h want 00", clock_divide); end
    rd(13'h00B);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL soft_0b: got %h want 00", rdData); end
    rd(13'h008);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL soft_08: got %h want 00", rdData); end
    rd(13'h005);
    checks++; if (rdData !== 8'h03) begin errors++; $display("FAIL soft_05: got %h want 03", rdData); end
    wr(13'h008, 8'h02);
    wr(13'h000, 8'h18);
    rd(13'h008);
    checks++; if (rdData !== 8'h02) begin errors++; $display("FAIL no_soft_18: got %h want 02", rdData); end
    wr(13'h000, 8'h04);
    rd(13'h008);
    checks++; if (rdData !== 8'h00) begin errors++; $display("FAIL soft_bit2: got %h want 00", rdData); end
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; Addr = '0; wrData = '0;
    test_reset();
    test_reset_release_edge();
    test_write_readback();
    test_latency();
    test_ro_unmapped();
    test_clk_div();
    test_hold_write();
    test_soft_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
